// File: rtl/hid_uart_pkg.sv
// Shared type codes, packet constants and state encodings for the HID UART injector.
// HID_UART_CHECKSUM_EN adds the checksum-check parser state.
package hid_uart_pkg;

  localparam logic [1:0] TYP_NONE  = 2'd0;
  localparam logic [1:0] TYP_KBD   = 2'd1;
  localparam logic [1:0] TYP_MOUSE = 2'd2;
  localparam logic [1:0] TYP_GAME  = 2'd3;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int unsigned PAYLOAD_LEN = 6;

  typedef enum logic [2:0] {
    PsIdle,
    PsType,
    PsPayload,
`ifdef HID_UART_CHECKSUM_EN
    PsChk,
`endif
    PsCommit
  } parser_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, glitch-rejecting start check.
module uart_rx_byte
  import hid_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       ferr
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

  logic [1:0]      sync_q;
  logic            rx_s;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_d, ferr_d;

  assign rx_s = sync_q[1];
  assign data = shift_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RxIdle: begin
        if (!rx_s) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A start bit that has gone high again by mid-bit was a glitch.
          state_d = rx_s ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == FullCnt) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RxStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == FullCnt) begin
          state_d = RxIdle;
          valid_d = rx_s;
          ferr_d  = !rx_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= 2'b11;
      state_q    <= RxIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], uart_rx};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_valid <= valid_d;
      ferr       <= ferr_d;
    end
  end

endmodule

// File: rtl/hid_uart_injector.sv
// Decodes framed HID reports from a UART into the usb_hid_host report interface.
// Define HID_UART_CHECKSUM_EN to require a trailing XOR checksum byte.
module hid_uart_injector
  import hid_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TIMEOUT_CLKS = 12000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic [1:0] typ,
  output logic       report,
  output logic [7:0] key_modifiers,
  output logic [7:0] key1,
  output logic [7:0] key2,
  output logic [7:0] key3,
  output logic [7:0] key4,
  output logic [7:0] mouse_btn,
  output logic [7:0] mouse_dx,
  output logic [7:0] mouse_dy,
  output logic       game_l,
  output logic       game_r,
  output logic       game_u,
  output logic       game_d,
  output logic       game_a,
  output logic       game_b,
  output logic       game_x,
  output logic       game_y,
  output logic       game_sel,
  output logic       game_sta,
  output logic       conerr
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS + 1);
  // p5 carries nothing in any report type; it is only counted and checksummed.
  localparam int unsigned StoreLen = PAYLOAD_LEN - 1;

  logic [7:0] rx_data;
  logic       byte_valid, ferr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .resetn    (resetn),
    .uart_rx   (uart_rx),
    .data      (rx_data),
    .byte_valid(byte_valid),
    .ferr      (ferr)
  );

  parser_state_e   state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [1:0]      ptyp_q, ptyp_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      pl_q [StoreLen];
  logic            store, err_d;
`ifdef HID_UART_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptyp_d  = ptyp_q;
    store   = 1'b0;
    err_d   = 1'b0;
`ifdef HID_UART_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    if (state_q == PsIdle || byte_valid) tmo_d = '0;
    else                                 tmo_d = tmo_q + 1'b1;

    if (ferr) begin
      err_d   = 1'b1;
      state_d = PsIdle;
    end else if (byte_valid) begin
      // A byte arriving on the timeout cycle wins, so this branch sits above the timeout.
      case (state_q)
        PsIdle: if (rx_data == SYNC_BYTE) state_d = PsType;
        PsType: begin
          if (rx_data[7:2] == 6'd0 && rx_data[1:0] != TYP_NONE) begin
            ptyp_d  = rx_data[1:0];
            idx_d   = '0;
            state_d = PsPayload;
`ifdef HID_UART_CHECKSUM_EN
            chk_d   = rx_data;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = PsIdle;
          end
        end
        PsPayload: begin
          store = 1'b1;
          idx_d = idx_q + 1'b1;
`ifdef HID_UART_CHECKSUM_EN
          chk_d = chk_q ^ rx_data;
          if (idx_q == 3'(PAYLOAD_LEN - 1)) state_d = PsChk;
`else
          if (idx_q == 3'(PAYLOAD_LEN - 1)) state_d = PsCommit;
`endif
        end
`ifdef HID_UART_CHECKSUM_EN
        PsChk: begin
          if (rx_data == chk_q) begin
            state_d = PsCommit;
          end else begin
            err_d   = 1'b1;
            state_d = PsIdle;
          end
        end
`endif
        default: ;
      endcase
    end else if (state_q != PsIdle && state_q != PsCommit &&
                 tmo_q == TmoW'(TIMEOUT_CLKS - 1)) begin
      err_d   = 1'b1;
      state_d = PsIdle;
    end

    if (state_q == PsCommit) state_d = PsIdle;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= PsIdle;
      idx_q   <= '0;
      ptyp_q  <= TYP_NONE;
      tmo_q   <= '0;
      for (int i = 0; i < StoreLen; i++) pl_q[i] <= '0;
`ifdef HID_UART_CHECKSUM_EN
      chk_q   <= '0;
`endif
      typ           <= TYP_NONE;
      report        <= 1'b0;
      conerr        <= 1'b0;
      key_modifiers <= '0;
      key1          <= '0;
      key2          <= '0;
      key3          <= '0;
      key4          <= '0;
      mouse_btn     <= '0;
      mouse_dx      <= '0;
      mouse_dy      <= '0;
      {game_y, game_x, game_b, game_a, game_d, game_u, game_r, game_l} <= '0;
      game_sel      <= 1'b0;
      game_sta      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptyp_q  <= ptyp_d;
      tmo_q   <= tmo_d;
`ifdef HID_UART_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
      for (int i = 0; i < StoreLen; i++) begin
        if (store && idx_q == 3'(i)) pl_q[i] <= rx_data;
      end
      report <= (state_q == PsCommit);
      conerr <= err_d;
      if (state_q == PsCommit) begin
        typ <= ptyp_q;
        case (ptyp_q)
          TYP_KBD: begin
            key_modifiers <= pl_q[0];
            key1          <= pl_q[1];
            key2          <= pl_q[2];
            key3          <= pl_q[3];
            key4          <= pl_q[4];
          end
          TYP_MOUSE: begin
            mouse_btn <= pl_q[0];
            mouse_dx  <= pl_q[1];
            mouse_dy  <= pl_q[2];
          end
          TYP_GAME: begin
            {game_y, game_x, game_b, game_a, game_d, game_u, game_r, game_l} <= pl_q[0];
            game_sel <= pl_q[1][0];
            game_sta <= pl_q[1][1];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hid_uart_injector.sv
// Directed bench for hid_uart_injector with a field-level report model checked every cycle.
module tb_hid_uart_injector;

  localparam int unsigned BIT = 16;
  localparam int unsigned TMO = 600;
`ifdef HID_UART_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] mods, k1, k2, k3, k4, btn, dx, dy;
    logic [9:0] game;  // {sta, sel, y, x, b, a, d, u, r, l}
  } fields_t;

  logic clk, resetn, rx;
  logic [1:0] typ;
  logic report, conerr;
  logic [7:0] key_modifiers, key1, key2, key3, key4, mouse_btn, mouse_dx, mouse_dy;
  logic game_l, game_r, game_u, game_d, game_a, game_b, game_x, game_y, game_sel, game_sta;

  hid_uart_injector #(
    .CLKS_PER_BIT(BIT),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .uart_rx      (rx),
    .typ          (typ),
    .report       (report),
    .key_modifiers(key_modifiers),
    .key1         (key1),
    .key2         (key2),
    .key3         (key3),
    .key4         (key4),
    .mouse_btn    (mouse_btn),
    .mouse_dx     (mouse_dx),
    .mouse_dy     (mouse_dy),
    .game_l       (game_l),
    .game_r       (game_r),
    .game_u       (game_u),
    .game_d       (game_d),
    .game_a       (game_a),
    .game_b       (game_b),
    .game_x       (game_x),
    .game_y       (game_y),
    .game_sel     (game_sel),
    .game_sta     (game_sta),
    .conerr       (conerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fields_t dut_f;
  assign dut_f = '{typ: typ, mods: key_modifiers, k1: key1, k2: key2, k3: key3, k4: key4,
                   btn: mouse_btn, dx: mouse_dx, dy: mouse_dy,
                   game: {game_sta, game_sel, game_y, game_x, game_b, game_a,
                          game_d, game_u, game_r, game_l}};

  int n_chk = 0;
  int n_fail = 0;
  int exp_rep = 0, exp_err = 0, n_rep_seen = 0, n_err_seen = 0;
  fields_t mdl = '0;   // state after every predicted commit
  fields_t cur = '0;   // state the outputs should show right now
  fields_t pend_q[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Report semantics straight from the packet rules.
  function automatic fields_t apply(input fields_t f, input logic [7:0] ty,
                                    input logic [47:0] pl);
    fields_t r = f;
    logic [7:0] p [6];
    for (int i = 0; i < 6; i++) p[i] = pl[47-8*i -: 8];
    r.typ = ty[1:0];
    if (ty == 8'd1) begin
      r.mods = p[0]; r.k1 = p[1]; r.k2 = p[2]; r.k3 = p[3]; r.k4 = p[4];
    end else if (ty == 8'd2) begin
      r.btn = p[0]; r.dx = p[1]; r.dy = p[2];
    end else begin
      r.game = {p[1][1], p[1][0], p[0]};
    end
    return r;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!resetn) cur = '0;
      if (conerr) n_err_seen++;
      if (report) begin
        n_rep_seen++;
        check("report_expected", 80'(pend_q.size() != 0), 80'(1));
        if (pend_q.size() != 0) cur = pend_q.pop_front();
      end
      check("fields", 80'(dut_f), 80'(cur));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BIT);
    end
    rx = stop;
    tick(BIT);
    rx = 1'b1;
    tick(4);
  endtask

  task automatic send_packet(input logic [7:0] ty, input logic [47:0] pl,
                             input logic [7:0] chk_adj);
    logic [7:0] chk;
    chk = ty;
    for (int i = 0; i < 6; i++) chk = chk ^ pl[47-8*i -: 8];
    if (ty >= 8'd1 && ty <= 8'd3 && (!ChkEn || chk_adj == 8'd0)) begin
      mdl = apply(mdl, ty, pl);
      pend_q.push_back(mdl);
      exp_rep++;
    end else begin
      exp_err++;
    end
    send_byte(8'hA5, 1'b1);
    send_byte(ty, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(pl[47-8*i -: 8], 1'b1);
    if (ChkEn) send_byte(chk ^ chk_adj, 1'b1);
    tick(4);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_reports"}, 80'(n_rep_seen), 80'(exp_rep));
    check({tag, "_conerrs"}, 80'(n_err_seen), 80'(exp_err));
  endtask

  initial begin
    rx = 1'b1;
    resetn = 1'b0;
    fork
      monitor();
    join_none
    tick(5);
    resetn = 1'b1;
    tick(5);
    check("reset_typ", 80'(typ), 80'(0));
    check("reset_report", 80'(report), 80'(0));
    check("reset_conerr", 80'(conerr), 80'(0));

    // Junk before sync is dropped silently.
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    tick(10);
    check_counts("junk");

    send_packet(8'h01, 48'h02_04_05_00_00_00, 8'h00);
    check("kbd_mods", 80'(key_modifiers), 80'(8'h02));
    check("kbd_key1", 80'(key1), 80'(8'h04));
    check("kbd_key2", 80'(key2), 80'(8'h05));
    check("kbd_typ", 80'(typ), 80'(1));
    check_counts("kbd");

    send_packet(8'h02, 48'h01_FB_05_00_00_00, 8'h00);
    check("mouse_btn", 80'(mouse_btn), 80'(8'h01));
    check("mouse_dx", 80'(mouse_dx), 80'(8'hFB));
    check("mouse_dy", 80'(mouse_dy), 80'(8'h05));
    check("mouse_typ", 80'(typ), 80'(2));
    check("mouse_kbd_hold", 80'(key_modifiers), 80'(8'h02));
    check_counts("mouse");

    send_packet(8'h03, 48'h11_02_00_00_00_00, 8'h00);
    check("game_bits", 80'({game_sta, game_sel, game_y, game_x, game_b, game_a,
                            game_d, game_u, game_r, game_l}), 80'(10'b10_0001_0001));
    check("game_typ", 80'(typ), 80'(3));
    check_counts("game");

    send_packet(8'h07, 48'h00_00_00_00_00_00, 8'h00);
    check("badtype_typ", 80'(typ), 80'(3));
    check_counts("badtype");

    // 0xA5 inside the payload is plain data.
    send_packet(8'h01, 48'hA5_11_22_33_44_55, 8'h00);
    check("a5data_mods", 80'(key_modifiers), 80'(8'hA5));
    check("a5data_key4", 80'(key4), 80'(8'h44));
    check_counts("a5data");

    // Stalled partial packet: no error well before the limit, one error after it.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    tick(400);
    check_counts("tmo_early");
    exp_err++;
    tick(300);
    check_counts("tmo_late");
    send_packet(8'h02, 48'h80_01_FF_00_00_00, 8'h00);
    check("after_tmo_dy", 80'(mouse_dy), 80'(8'hFF));
    check_counts("after_tmo");

    // Framing error in the middle of a packet.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    exp_err++;
    send_byte(8'h33, 1'b0);
    tick(300);
    check_counts("framing");
    send_packet(8'h01, 48'h10_20_30_40_50_60, 8'h00);
    check_counts("after_framing");

    if (ChkEn) begin
      send_packet(8'h01, 48'h02_04_05_00_00_00, 8'h01);
      check("badchk_mods", 80'(key_modifiers), 80'(8'h10));
      check_counts("badchk");
    end

    // Reset in the middle of a byte of a partial packet.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b0;
    tick(BIT * 3);
    resetn = 1'b0;
    mdl = '0;
    tick(3);
    check("midreset_fields", 80'(dut_f), 80'(0));
    rx = 1'b1;
    resetn = 1'b1;
    tick(50);
    check_counts("midreset");
    send_packet(8'h03, 48'h82_01_00_00_00_00, 8'h00);
    check("post_reset_typ", 80'(typ), 80'(3));
    check("post_reset_game", 80'({game_sta, game_sel, game_y, game_r}), 80'(4'b0111));
    check("post_reset_kbd", 80'(key_modifiers), 80'(0));
    check_counts("post_reset");

    tick(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
